// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, constants and helpers for the VGA colour composer
//
// Purpose: common definitions imported by the composer and its priority selector.
// Contents: rgb_t colour struct, active-area and sync-polarity constants,
//           popcount_ge2() used to detect two or more simultaneous object requests.

package vga_pkg;

  localparam int COLOR_W = 8;

  localparam int   H_ACTIVE    = 640;
  localparam int   V_ACTIVE    = 480;
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Clearing the lowest set bit leaves something behind only when at least
  // two bits were set; this avoids an adder tree for a simple >=2 test.
  function automatic logic popcount_ge2(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/obj_priority_sel.sv
// rtl/obj_priority_sel.sv - lowest-index-wins colour select across object layers
//
// Purpose: combinational priority mux of N_OBJ object colours over a background.
// Ports:
//   req_i       per-object request, bit 0 has the highest priority
//   obj_rgb_i   packed {R,G,B} per object, object i at [i*3*COLOR_W +: 3*COLOR_W]
//   bg_rgb_i    background {R,G,B}, used when no object requests
//   rgb_o       selected {R,G,B}
//   any_req_o   at least one object requests
//   multi_req_o two or more objects request (overlap)

module obj_priority_sel #(
  parameter int N_OBJ   = 4,
  parameter int COLOR_W = 8
) (
  input  logic [N_OBJ-1:0]           req_i,
  input  logic [N_OBJ*3*COLOR_W-1:0] obj_rgb_i,
  input  logic [3*COLOR_W-1:0]       bg_rgb_i,
  output logic [3*COLOR_W-1:0]       rgb_o,
  output logic                       any_req_o,
  output logic                       multi_req_o
);

  import vga_pkg::*;

  logic [31:0] req_ext;

  // Walk from the lowest priority up so the lowest requesting index is the
  // last assignment and therefore wins.
  always_comb begin
    rgb_o   = bg_rgb_i;
    req_ext = '0;
    req_ext[N_OBJ-1:0] = req_i;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        rgb_o = obj_rgb_i[i*3*COLOR_W +: 3*COLOR_W];
      end
    end
  end

  assign any_req_o   = |req_i;
  assign multi_req_o = popcount_ge2(req_ext);

endmodule

// File: rtl/vga_rgb_composer.sv
// rtl/vga_rgb_composer.sv - object/background colour composer with sync delay and frame statistics
//
// Purpose: two-stage pipeline that merges object layers over a background, blacks
// out the blanking area, keeps HS/VS/blank aligned with RGB, and produces a frame
// tick, a frame counter and per-frame object-overlap flags.
// Ports:
//   vga_clk, reset          pixel clock, asynchronous active-high reset
//   blank_n_in, hs_in, vs_in  timing from the sync generator (syncs active-low)
//   pixel_x, pixel_y        coordinates, carried for debug only
//   obj_req, obj_rgb, bg_rgb  object requests/colours and background colour
//   red, green, blue        composed colour, 2 cycles after the inputs
//   hs_out, vs_out, blank_n_out  timing delayed by the same 2 cycles
//   frame_tick              one-cycle pulse on each VS falling edge
//   frame_count             frames since reset, wrapping
//   coll_flags              objects that overlapped another during the previous frame

module vga_rgb_composer #(
  parameter int N_OBJ       = 4,
  parameter int COLOR_W     = 8,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic                       blank_n_in,
  input  logic                       hs_in,
  input  logic                       vs_in,
  input  logic [10:0]                pixel_x,
  input  logic [10:0]                pixel_y,
  input  logic [N_OBJ-1:0]           obj_req,
  input  logic [N_OBJ*3*COLOR_W-1:0] obj_rgb,
  input  logic [3*COLOR_W-1:0]       bg_rgb,
  output logic [COLOR_W-1:0]         red,
  output logic [COLOR_W-1:0]         green,
  output logic [COLOR_W-1:0]         blue,
  output logic                       hs_out,
  output logic                       vs_out,
  output logic                       blank_n_out,
  output logic                       frame_tick,
  output logic [FRAME_CNT_W-1:0]     frame_count,
  output logic [N_OBJ-1:0]           coll_flags
);

  import vga_pkg::*;

  localparam int RGB_W = 3 * COLOR_W;

  // Stage 1
  logic                       blank1_q;
  logic                       hs1_q;
  logic                       vs1_q;
  logic [N_OBJ-1:0]           req1_q;
  logic [N_OBJ*RGB_W-1:0]     obj_rgb1_q;
  logic [RGB_W-1:0]           bg_rgb1_q;
  logic [21:0]                dbg_xy_unused_q;

  // Stage 2 and frame state
  logic [RGB_W-1:0]           rgb2_q,  rgb2_d;
  logic                       hs2_q;
  logic                       vs2_q;
  logic                       blank2_q;
  logic                       tick_q;
  logic                       vs_hist_q;
  logic [FRAME_CNT_W-1:0]     cnt_q,   cnt_d;
  logic [N_OBJ-1:0]           acc_q,   acc_d;
  logic [N_OBJ-1:0]           coll_q,  coll_d;

  logic [RGB_W-1:0]           sel_rgb;
  logic                       any_req;
  logic                       multi_req;
  logic                       vs_fall;
  logic                       overlap_now;

  obj_priority_sel #(
    .N_OBJ   (N_OBJ),
    .COLOR_W (COLOR_W)
  ) u_sel (
    .req_i       (req1_q),
    .obj_rgb_i   (obj_rgb1_q),
    .bg_rgb_i    (bg_rgb1_q),
    .rgb_o       (sel_rgb),
    .any_req_o   (any_req),
    .multi_req_o (multi_req)
  );

  always_comb begin
    rgb2_d      = blank1_q ? sel_rgb : '0;
    vs_fall     = vs_hist_q & ~vs1_q;
    overlap_now = blank1_q & any_req & multi_req;
    acc_d       = acc_q;
    coll_d      = coll_q;
    cnt_d       = cnt_q;
    // An overlap seen on the tick cycle itself belongs to the frame that is
    // closing, so it is folded into the reported flags, not the new frame.
    if (vs_fall) begin
      coll_d = acc_q | (overlap_now ? req1_q : '0);
      acc_d  = '0;
      cnt_d  = cnt_q + FRAME_CNT_W'(1);
    end else if (overlap_now) begin
      acc_d  = acc_q | req1_q;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank1_q        <= 1'b0;
      hs1_q           <= ~SYNC_ACTIVE;
      vs1_q           <= ~SYNC_ACTIVE;
      req1_q          <= '0;
      obj_rgb1_q      <= '0;
      bg_rgb1_q       <= '0;
      dbg_xy_unused_q <= '0;
      rgb2_q          <= '0;
      hs2_q           <= ~SYNC_ACTIVE;
      vs2_q           <= ~SYNC_ACTIVE;
      blank2_q        <= 1'b0;
      tick_q          <= 1'b0;
      vs_hist_q       <= ~SYNC_ACTIVE;
      cnt_q           <= '0;
      acc_q           <= '0;
      coll_q          <= '0;
    end else begin
      blank1_q        <= blank_n_in;
      hs1_q           <= hs_in;
      vs1_q           <= vs_in;
      req1_q          <= obj_req;
      obj_rgb1_q      <= obj_rgb;
      bg_rgb1_q       <= bg_rgb;
      dbg_xy_unused_q <= {pixel_x, pixel_y};
      rgb2_q          <= rgb2_d;
      hs2_q           <= hs1_q;
      vs2_q           <= vs1_q;
      blank2_q        <= blank1_q;
      tick_q          <= vs_fall;
      vs_hist_q       <= vs1_q;
      cnt_q           <= cnt_d;
      acc_q           <= acc_d;
      coll_q          <= coll_d;
    end
  end

  assign red         = rgb2_q[RGB_W-1 -: COLOR_W];
  assign green       = rgb2_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = rgb2_q[COLOR_W-1:0];
  assign hs_out      = hs2_q;
  assign vs_out      = vs2_q;
  assign blank_n_out = blank2_q;
  assign frame_tick  = tick_q;
  assign frame_count = cnt_q;
  assign coll_flags  = coll_q;

endmodule

// File: tb/tb_vga_rgb_composer.sv
// tb/tb_vga_rgb_composer.sv - scoreboard bench for vga_rgb_composer

module tb_vga_rgb_composer;

  localparam int N_OBJ = 4;
  localparam int CW    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        blank_n_in, hs_in, vs_in;
  logic [10:0] pixel_x, pixel_y;
  logic [3:0]  obj_req;
  logic [95:0] obj_rgb;
  logic [23:0] bg_rgb;

  logic [7:0]  red, green, blue;
  logic        hs_out, vs_out, blank_n_out, frame_tick;
  logic [15:0] frame_count;
  logic [3:0]  coll_flags;

  logic [7:0]  w_red, w_green, w_blue;
  logic        w_hs, w_vs, w_blank, w_tick;
  logic [1:0]  w_count;
  logic [3:0]  w_coll;

  always #5 clk = ~clk;

  vga_rgb_composer #(.N_OBJ(N_OBJ), .COLOR_W(CW), .FRAME_CNT_W(16)) dut (
    .vga_clk(clk), .reset(reset), .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .obj_req(obj_req), .obj_rgb(obj_rgb), .bg_rgb(bg_rgb),
    .red(red), .green(green), .blue(blue), .hs_out(hs_out), .vs_out(vs_out),
    .blank_n_out(blank_n_out), .frame_tick(frame_tick), .frame_count(frame_count),
    .coll_flags(coll_flags)
  );

  vga_rgb_composer #(.N_OBJ(N_OBJ), .COLOR_W(CW), .FRAME_CNT_W(2)) dut_w (
    .vga_clk(clk), .reset(reset), .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .obj_req(obj_req), .obj_rgb(obj_rgb), .bg_rgb(bg_rgb),
    .red(w_red), .green(w_green), .blue(w_blue), .hs_out(w_hs), .vs_out(w_vs),
    .blank_n_out(w_blank), .frame_tick(w_tick), .frame_count(w_count),
    .coll_flags(w_coll)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        tick;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic [3:0]  coll;
  } obs_t;

  obs_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ticks_seen = 0;

  logic        m_prev_vs;
  logic [3:0]  m_acc;
  logic [3:0]  m_coll;
  logic [15:0] m_cnt;

  function automatic obs_t observe();
    obs_t o;
    o.rgb   = {red, green, blue};
    o.hs    = hs_out;
    o.vs    = vs_out;
    o.blank = blank_n_out;
    o.tick  = frame_tick;
    o.cnt   = frame_count;
    o.cnt2  = w_count;
    o.coll  = coll_flags;
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_vs = 1'b1;
    m_acc     = '0;
    m_coll    = '0;
    m_cnt     = '0;
    sb_q.delete();
  endtask

  // Predict the output of the current input sample, queue it, advance one
  // cycle, then compare the sample queued one step earlier (2-cycle latency).
  task automatic step();
    obs_t        e;
    logic        ov;
    logic [23:0] c;
    c = 24'h0;
    if (blank_n_in) begin
      c = bg_rgb;
      for (int i = 0; i < N_OBJ; i++) begin
        if (obj_req[i]) begin
          c = obj_rgb[i*24 +: 24];
          break;
        end
      end
    end
    e.tick    = m_prev_vs & ~vs_in;
    m_prev_vs = vs_in;
    ov = blank_n_in && ($countones(obj_req) >= 2);
    if (e.tick) begin
      m_coll = m_acc | (ov ? obj_req : 4'b0000);
      m_acc  = '0;
      m_cnt  = m_cnt + 16'd1;
    end else if (ov) begin
      m_acc = m_acc | obj_req;
    end
    e.rgb   = c;
    e.hs    = hs_in;
    e.vs    = vs_in;
    e.blank = blank_n_in;
    e.cnt   = m_cnt;
    e.cnt2  = m_cnt[1:0];
    e.coll  = m_coll;
    sb_q.push_back(e);
    pixel_x = pixel_x + 11'd1;
    @(negedge clk);
    if (frame_tick) ticks_seen++;
    if (sb_q.size() == 2) check("pipe", observe(), sb_q.pop_front());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic vs_pulse(input int low_cycles);
    blank_n_in = 1'b0;
    vs_in = 1'b0;
    steps(low_cycles);
    vs_in = 1'b1;
    steps(4);
    blank_n_in = 1'b1;
    steps(2);
  endtask

  initial begin
    reset      = 1'b1;
    blank_n_in = 1'b1;
    hs_in      = 1'b1;
    vs_in      = 1'b1;
    pixel_x    = '0;
    pixel_y    = '0;
    obj_req    = 4'b0000;
    obj_rgb    = {24'h777777, 24'h00FF00, 24'hFF0000, 24'h0000FF};
    bg_rgb     = 24'h000000;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_rgb",   {red, green, blue}, 24'h000000);
    check("rst_hs",    hs_out, 1'b1);
    check("rst_vs",    vs_out, 1'b1);
    check("rst_blank", blank_n_out, 1'b0);
    check("rst_cnt",   frame_count, 16'd0);
    check("rst_coll",  coll_flags, 4'b0000);
    check("rst_tick",  frame_tick, 1'b0);
    reset = 1'b0;

    bg_rgb = 24'h102030;
    steps(3);
    check("bg_colour", {red, green, blue}, 24'h102030);

    obj_req = 4'b0110;
    steps(2);
    check("prio_obj1", {red, green, blue}, 24'hFF0000);

    blank_n_in = 1'b0;
    steps(2);
    check("blank_black", {red, green, blue}, 24'h000000);
    check("blank_out_lo", blank_n_out, 1'b0);
    blank_n_in = 1'b1;
    step();
    check("blank_delay1", blank_n_out, 1'b0);
    step();
    check("blank_delay2", blank_n_out, 1'b1);

    hs_in = 1'b0;
    step();
    check("hs_delay1", hs_out, 1'b1);
    step();
    check("hs_delay2", hs_out, 1'b0);
    hs_in = 1'b1;
    steps(2);
    check("hs_back", hs_out, 1'b1);

    for (int k = 0; k < 16; k++) begin
      obj_req = 4'(k);
      bg_rgb  = 24'($urandom);
      obj_rgb[72 +: 24] = 24'($urandom);
      step();
    end
    obj_req = 4'b0000;
    steps(2);

    ticks_seen = 0;
    repeat (3) vs_pulse(1600);
    check("tick_count", ticks_seen, 3);
    check("frame_cnt3", frame_count, 16'd3);
    check("wrap_cnt3",  w_count, 2'd3);

    obj_req = 4'b0011; step();
    obj_req = 4'b0100; step();
    obj_req = 4'b0000; steps(3);
    vs_pulse(4);
    check("coll_0011",  coll_flags, 4'b0011);
    check("frame_cnt4", frame_count, 16'd4);
    check("wrap_cnt0",  w_count, 2'd0);

    obj_req = 4'b0100; step();
    obj_req = 4'b0001; step();
    obj_req = 4'b1000; step();
    obj_req = 4'b0000; steps(3);
    vs_pulse(4);
    check("coll_none", coll_flags, 4'b0000);

    blank_n_in = 1'b1;
    vs_in      = 1'b0;
    obj_req    = 4'b0101;
    step();
    obj_req    = 4'b0000;
    blank_n_in = 1'b0;
    steps(3);
    vs_in = 1'b1;
    steps(4);
    blank_n_in = 1'b1;
    steps(2);
    check("coll_on_tick", coll_flags, 4'b0101);

    obj_req = 4'b1001; step();
    obj_req = 4'b0000; steps(2);
    reset = 1'b1;
    #1;
    check("midrst_coll", coll_flags, 4'b0000);
    check("midrst_cnt",  frame_count, 16'd0);
    check("midrst_rgb",  {red, green, blue}, 24'h000000);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    obj_req = 4'b0100; steps(3);
    obj_req = 4'b0000;
    vs_pulse(4);
    check("post_rst_coll", coll_flags, 4'b0000);
    check("post_rst_cnt",  frame_count, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_rgb_composer.md
Name: vga_rgb_composer

Overview:
- Downstream consumer of the VGA sync/pixel-coordinate generator; sits between the game object drawers and the DAC/VGA pins.
- Merges per-object draw requests and colours with a background colour using fixed priority. Forces black outside the visible area.
- Delays HS/VS/blank_n so they stay aligned with the RGB output.
- Produces a per-frame tick, a frame counter, and per-frame object-overlap (collision) flags for game logic.

Parameters:
- N_OBJ, 4, number of object layers; index 0 has the highest priority.
- COLOR_W, 8, bits per colour channel.
- FRAME_CNT_W, 16, frame counter width.

Ports:
- vga_clk  in  1  pixel clock; all state updates on the rising edge (the sync generator drives on the falling edge).
- reset  in  1  asynchronous, active-high.
- blank_n_in  in  1  visible-area flag from the sync generator.
- hs_in  in  1  horizontal sync, active-low.
- vs_in  in  1  vertical sync, active-low.
- pixel_x  in  11  current pixel X (valid when blank_n_in=1).
- pixel_y  in  11  current pixel Y (valid when blank_n_in=1).
- obj_req  in  N_OBJ  per-object "pixel belongs to me", aligned with pixel_x/pixel_y.
- obj_rgb  in  N_OBJ*3*COLOR_W  packed colours; object i occupies bits [i*3*COLOR_W +: 3*COLOR_W], order {R,G,B}.
- bg_rgb  in  3*COLOR_W  background colour {R,G,B}.
- red  out  COLOR_W  red channel.
- green  out  COLOR_W  green channel.
- blue  out  COLOR_W  blue channel.
- hs_out  out  1  delayed HS.
- vs_out  out  1  delayed VS.
- blank_n_out  out  1  delayed blank_n.
- frame_tick  out  1  one-cycle pulse at each frame start.
- frame_count  out  FRAME_CNT_W  frames since reset; wraps to 0.
- coll_flags  out  N_OBJ  objects that overlapped another object during the previous frame.

Behaviour:
- Reset values: red/green/blue=0, hs_out=1, vs_out=1, blank_n_out=0, frame_tick=0, frame_count=0, coll_flags=0, collision accumulator=0, internal vs history=1.
- Pipeline, 2 cycles fixed:
  - Stage 1 registers blank_n_in, hs_in, vs_in, obj_req, obj_rgb, bg_rgb.
  - Stage 2 registers the selected colour, hs, vs and blank.
  - Any input at edge k appears on the outputs after edge k+2.
- Colour select (stage 2):
  - If stage-1 blank=0, output 0/0/0.
  - Else, output the colour of the lowest-index i with req[i]=1.
  - Else, output bg_rgb.
  - pixel_x/pixel_y do not affect colour; they are pipelined for debug only and may be left unconnected by synthesis.
- Frame tick:
  - A falling edge of the stage-1 vs (previous 1, current 0) asserts frame_tick for exactly one cycle, at the same edge the stage-2 outputs update.
  - frame_count increments on that same edge and wraps from 2^FRAME_CNT_W-1 to 0.
  - vs held low for many cycles produces exactly one tick.
- Collision detection (stage 1 → accumulator):
  - Overlap occurs when stage-1 blank=1 and popcount(req)>=2.
  - On overlap: acc |= req. Objects requesting alone do not set their bits.
- Frame boundary:
  - On the frame_tick edge: coll_flags <= acc | overlap_now; acc <= 0.
  - overlap_now is normally 0 because VS falls inside blanking; the rule still defines the behaviour if blank_n glitches.
- coll_flags holds its value for the entire following frame.
- Reset mid-frame: everything returns to reset values immediately. The first tick after reset reports flags accumulated only since reset.
- The first VS falling edge after reset produces frame_tick, and frame_count becomes 1.

Decomposition:
- Package vga_pkg:
  - rgb_t packed struct {r,g,b} of COLOR_W each.
  - Constants H_ACTIVE=640, V_ACTIVE=480, SYNC_ACTIVE=1'b0.
  - Function popcount_ge2.
- Sub-module obj_priority_sel:
  - Combinational lowest-index-wins select of N_OBJ colours plus background.
  - Also reports any_req and multi_req for the overlap logic.

Test Plan:
- Reset with blank_n_in=1, obj_req=0 → outputs red=green=blue=0, hs_out=vs_out=1, blank_n_out=0, frame_count=0.
- blank_n_in=1, obj_req=4'b0000, bg_rgb=24'h102030 → 2 edges later {red,green,blue}=24'h102030; obj_req=4'b0110 with obj1=FF0000, obj2=00FF00 → FF0000 (obj1 wins).
- Same request with blank_n_in=0 → 000000; toggle hs_in 1→0 at edge k → hs_out goes 0 after edge k+2, and blank_n_out tracks blank_n_in with the same 2-cycle delay.
- vs_in driven low for 1600 cycles, three times → exactly 3 single-cycle frame_tick pulses, frame_count 1,2,3; preload wrap test with FRAME_CNT_W=2 → 3 then 0.
- Frame N: obj_req=4'b0011 for one visible cycle, plus 4'b0100 alone → after the next tick coll_flags=4'b0011; frame N+1 with no overlap → next tick coll_flags=4'b0000.
- Assert reset mid-frame after an overlap of 4'b1001 → coll_flags=0 and accumulator cleared; the next tick reports 4'b0000.
